// File: rtl/fetch_buffer.sv
// -----------------------------------------------------------------------------
// fetch_buffer
//
// Instruction fetch queue between the instruction memory port and decode.
// Issues sequential word-aligned fetch requests, collects the in-order
// responses into a DEPTH-entry FIFO of {pc, instr, fault}, and presents the
// head entry to the decoder. A redirect flushes the queue and restarts fetch;
// responses to requests issued before the redirect are counted as stale and
// silently discarded when they return.
//
// A request is only issued while occupancy + inflight + stale < DEPTH, so
// every response that can arrive is guaranteed a free queue slot (the memory
// side has no backpressure).
//
// Configuration macro:
//   FETCH_BUFFER_BYPASS_EN  - when defined, a non-stale response arriving
//                             while the queue is empty is forwarded
//                             combinationally to out_* in the same cycle
//                             (and only written if decode stalls). When
//                             undefined, out_* come from the queue registers
//                             and an entry is visible one cycle after its
//                             response.
//
// Parameters:
//   DEPTH       queue entries, power of two in 2..16
//   START_ADDR  first fetch address after reset
//
// Ports:
//   clock            rising-edge clock
//   reset            asynchronous active-low reset
//   imem_req_valid   fetch request valid
//   imem_req_ready   memory accepts request this cycle
//   imem_req_addr    word-aligned fetch address
//   imem_resp_valid  response beat, in request order
//   imem_resp_rdata  fetched instruction word
//   imem_resp_error  access fault for this beat
//   redirect_valid   flush and restart fetch
//   redirect_pc      restart address (bits [1:0] forced to 0)
//   out_valid        head entry valid toward decode
//   out_ready        decode consumes head this cycle
//   out_pc           PC of head entry
//   out_instr        instruction word of head entry
//   out_fault        head entry carries an access fault
// -----------------------------------------------------------------------------
module fetch_buffer #(
  parameter int unsigned DEPTH      = 4,
  parameter logic [31:0] START_ADDR = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_rdata,
  input  logic        imem_resp_error,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_fault
);

  localparam int unsigned    PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned    CNT_W   = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_S = (CNT_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] ZERO_C = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PONE_C = PTR_W'(1);

  // Queue storage
  logic [31:0]      pc_mem_q    [DEPTH];
  logic [31:0]      instr_mem_q [DEPTH];
  logic             fault_mem_q [DEPTH];

  // Pointers, counters and PCs
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic [CNT_W-1:0] stale_q, stale_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      resp_pc_q, resp_pc_d;    // PC owed to the next non-stale response

  logic             budget_ok_s;
  logic             req_valid_s;
  logic             accept_s;
  logic             resp_live_s;
  logic             push_s;
  logic             pop_s;
  logic [31:0]      redirect_aligned_s;
`ifdef FETCH_BUFFER_BYPASS_EN
  logic             bypass_s;
`endif

  assign imem_req_valid = req_valid_s;
  assign imem_req_addr  = fetch_pc_q;

  // Handshake qualification and head-of-queue presentation
  always_comb begin
    redirect_aligned_s = redirect_pc & 32'hFFFF_FFFC;
    budget_ok_s = ({1'b0, count_q} + {1'b0, inflight_q} + {1'b0, stale_q}) < DEPTH_S;
    // Gating with reset keeps the request low while reset is held.
    req_valid_s = reset & budget_ok_s & ~redirect_valid;
    accept_s    = req_valid_s & imem_req_ready;
    // A response in a redirect cycle is dropped along with the stale ones.
    resp_live_s = reset & imem_resp_valid & (stale_q == ZERO_C) & ~redirect_valid;
    pop_s       = (count_q != ZERO_C) & out_ready & ~redirect_valid;
`ifdef FETCH_BUFFER_BYPASS_EN
    bypass_s = resp_live_s & (count_q == ZERO_C);
    // A bypassed entry consumed immediately never occupies a slot.
    push_s   = resp_live_s & ~(bypass_s & out_ready);
    if (bypass_s) begin
      out_valid = 1'b1;
      out_pc    = resp_pc_q;
      out_instr = imem_resp_rdata;
      out_fault = imem_resp_error;
    end else begin
      out_valid = (count_q != ZERO_C);
      out_pc    = pc_mem_q[head_q];
      out_instr = instr_mem_q[head_q];
      out_fault = fault_mem_q[head_q];
    end
`else
    push_s    = resp_live_s;
    out_valid = (count_q != ZERO_C);
    out_pc    = pc_mem_q[head_q];
    out_instr = instr_mem_q[head_q];
    out_fault = fault_mem_q[head_q];
`endif
  end

  // Next-state for pointers, counters and fetch PCs
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    inflight_d = inflight_q;
    stale_d    = stale_q;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    if (redirect_valid) begin
      // Everything outstanding, plus anything accepted now, becomes stale;
      // a response arriving in this cycle retires one of them.
      head_d     = {PTR_W{1'b0}};
      tail_d     = {PTR_W{1'b0}};
      count_d    = ZERO_C;
      inflight_d = ZERO_C;
      stale_d    = stale_q + inflight_q + (accept_s ? ONE_C : ZERO_C)
                   - (imem_resp_valid ? ONE_C : ZERO_C);
      fetch_pc_d = redirect_aligned_s;
      resp_pc_d  = redirect_aligned_s;
    end else begin
      if (accept_s) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end else begin
        fetch_pc_d = fetch_pc_q;
      end
      if (resp_live_s) begin
        resp_pc_d = resp_pc_q + 32'd4;
      end else begin
        resp_pc_d = resp_pc_q;
      end
      // Stale beats are always the oldest, so they drain first.
      if (imem_resp_valid && (stale_q != ZERO_C)) begin
        stale_d = stale_q - ONE_C;
      end else begin
        stale_d = stale_q;
      end
      inflight_d = inflight_q + (accept_s ? ONE_C : ZERO_C)
                   - (resp_live_s ? ONE_C : ZERO_C);
      if (push_s) begin
        tail_d = tail_q + PONE_C;
      end else begin
        tail_d = tail_q;
      end
      if (pop_s) begin
        head_d = head_q + PONE_C;
      end else begin
        head_d = head_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + ONE_C;
        2'b01:   count_d = count_q - ONE_C;
        default: count_d = count_q;
      endcase
    end
  end

  // State registers and queue storage
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q     <= {PTR_W{1'b0}};
      tail_q     <= {PTR_W{1'b0}};
      count_q    <= ZERO_C;
      inflight_q <= ZERO_C;
      stale_q    <= ZERO_C;
      fetch_pc_q <= START_ADDR;
      resp_pc_q  <= START_ADDR;
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_mem_q[i]    <= 32'h0000_0000;
        instr_mem_q[i] <= 32'h0000_0000;
        fault_mem_q[i] <= 1'b0;
      end
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      stale_q    <= stale_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      if (push_s) begin
        pc_mem_q[tail_q]    <= resp_pc_q;
        instr_mem_q[tail_q] <= imem_resp_rdata;
        fault_mem_q[tail_q] <= imem_resp_error;
      end
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
`timescale 1ns/1ps
module tb_fetch_buffer;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] START = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_rdata;
  logic        imem_resp_error;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_fault;

  fetch_buffer #(.DEPTH(DEPTH), .START_ADDR(START)) dut (
    .clock(clock), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_rdata(imem_resp_rdata),
    .imem_resp_error(imem_resp_error),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_instr(out_instr), .out_fault(out_fault)
  );

  always #5 clock = ~clock;

  // Memory model: outstanding requests tagged with the fetch epoch they belong to
  typedef struct { logic [31:0] addr; int due; int epoch; } req_t;
  // Reference queue: entries the decoder is owed, oldest first
  typedef struct { logic [31:0] pc; logic [31:0] instr; logic fault; } ent_t;

  req_t        memq[$];
  ent_t        refq[$];
  int          cyc, epoch, checks, failures;
  logic [31:0] exp_fetch_pc;
  bit          hold_resp, fault_rand;
  int          lat_min, lat_max;
  logic [31:0] fault_addr;
  logic [31:0] acc_addr[$];
  int          acc_cyc[$];
  logic [31:0] pop_pc[$];
  logic        pop_fault[$];
  bit          obs_ov[$];

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic fault_of(input logic [31:0] a);
    return (a == fault_addr) || (fault_rand && (a[4:2] == 3'd5));
  endfunction

  task automatic clear_records();
    acc_addr.delete(); acc_cyc.delete(); pop_pc.delete(); pop_fault.delete(); obs_ov.delete();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    imem_resp_valid = 1'b0; imem_resp_rdata = 32'h0; imem_resp_error = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    memq.delete(); refq.delete(); epoch = 0; exp_fetch_pc = START;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    cyc = 0;
  endtask

  // One clock cycle: drive memory response, compare DUT against the model, advance model.
  task automatic step();
    ent_t live_e, head_e;
    bit   live, exp_rv, exp_ov, resp_now;
    resp_now = !hold_resp && (memq.size() > 0) && (memq[0].due <= cyc);
    imem_resp_valid = resp_now;
    if (resp_now) begin
      imem_resp_rdata = data_of(memq[0].addr);
      imem_resp_error = fault_of(memq[0].addr);
    end else begin
      imem_resp_rdata = $urandom;
      imem_resp_error = 1'b0;
    end
    #4;
    exp_rv = ((refq.size() + memq.size()) < int'(DEPTH)) && !redirect_valid;
    checks++;
    if (imem_req_valid !== exp_rv) begin
      failures++;
      $display("FAIL req_valid cyc=%0d got=%b exp=%b", cyc, imem_req_valid, exp_rv);
    end
    if (exp_rv) begin
      checks++;
      if (imem_req_addr !== exp_fetch_pc) begin
        failures++;
        $display("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, imem_req_addr, exp_fetch_pc);
      end
    end
    live = resp_now && (memq[0].epoch == epoch) && !redirect_valid;
    live_e.pc = 32'h0; live_e.instr = 32'h0; live_e.fault = 1'b0;
    if (live) begin
      live_e.pc    = memq[0].addr;
      live_e.instr = data_of(memq[0].addr);
      live_e.fault = fault_of(memq[0].addr);
    end
`ifdef FETCH_BUFFER_BYPASS_EN
    exp_ov = (refq.size() > 0) || live;
`else
    exp_ov = (refq.size() > 0);
`endif
    if (refq.size() > 0) head_e = refq[0];
    else                 head_e = live_e;
    checks++;
    if (out_valid !== exp_ov) begin
      failures++;
      $display("FAIL out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, exp_ov);
    end
    if (exp_ov) begin
      checks++;
      if (out_pc !== head_e.pc || out_instr !== head_e.instr || out_fault !== head_e.fault) begin
        failures++;
        $display("FAIL out_entry cyc=%0d got=%h/%h/%b exp=%h/%h/%b", cyc, out_pc, out_instr,
                 out_fault, head_e.pc, head_e.instr, head_e.fault);
      end
    end
    obs_ov.push_back(out_valid);
    if (imem_req_valid && imem_req_ready) begin
      acc_addr.push_back(imem_req_addr); acc_cyc.push_back(cyc);
    end
    if (out_valid && out_ready && !redirect_valid) begin
      pop_pc.push_back(out_pc); pop_fault.push_back(out_fault);
    end
    if (resp_now) void'(memq.pop_front());
    if (redirect_valid) begin
      refq.delete();
      epoch++;
      exp_fetch_pc = redirect_pc & 32'hFFFF_FFFC;
    end else begin
      if (live) refq.push_back(live_e);
      if (exp_ov && out_ready) void'(refq.pop_front());
      if (exp_rv && imem_req_ready) begin
        memq.push_back('{addr: exp_fetch_pc,
                         due: cyc + int'($urandom_range(lat_min, lat_max)),
                         epoch: epoch});
        exp_fetch_pc = exp_fetch_pc + 32'd4;
      end
    end
    @(posedge clock);
    #1 cyc++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    imem_req_ready = 1'b1; out_ready = 1'b1; imem_resp_valid = 1'b0;
    imem_resp_rdata = 32'h0; imem_resp_error = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    #1 reset = 1'b0;
    #2;
    checks++;
    if (imem_req_valid !== 1'b0 || imem_req_addr !== START || out_valid !== 1'b0 ||
        out_pc !== 32'h0 || out_instr !== 32'h0 || out_fault !== 1'b0) begin
      failures++;
      $display("FAIL reset_values got=%b/%h/%b/%h/%h/%b", imem_req_valid, imem_req_addr,
               out_valid, out_pc, out_instr, out_fault);
    end
    do_reset();
    #1;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== START) begin
      failures++;
      $display("FAIL first_req got=%b/%h exp=1/%h", imem_req_valid, imem_req_addr, START);
    end
    repeat (3) step();
  endtask

  task automatic test_sequential();
    do_reset(); clear_records();
    hold_resp = 0; lat_min = 1; lat_max = 1;
    imem_req_ready = 1'b1; out_ready = 1'b1;
    repeat (10) step();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= acc_addr.size() || acc_addr[i] !== 32'(4 * i)) begin
        failures++;
        $display("FAIL seq_req_addr idx=%0d got=%h exp=%h", i,
                 (i < acc_addr.size()) ? acc_addr[i] : 32'hDEAD_BEEF, 32'(4 * i));
      end
      checks++;
      if (i >= pop_pc.size() || pop_pc[i] !== 32'(4 * i)) begin
        failures++;
        $display("FAIL seq_out_pc idx=%0d got=%h exp=%h", i,
                 (i < pop_pc.size()) ? pop_pc[i] : 32'hDEAD_BEEF, 32'(4 * i));
      end
    end
    checks++;
    if (acc_cyc.size() < 3 || (acc_cyc[2] - acc_cyc[0]) != 2) begin
      failures++;
      $display("FAIL back_to_back got=%0d exp=2", (acc_cyc.size() < 3) ? -1 : acc_cyc[2] - acc_cyc[0]);
    end
  endtask

  task automatic test_stall();
    do_reset(); clear_records();
    hold_resp = 0; lat_min = 1; lat_max = 1;
    imem_req_ready = 1'b1; out_ready = 1'b0;
    repeat (12) step();
    checks++;
    if (acc_addr.size() != int'(DEPTH)) begin
      failures++;
      $display("FAIL stall_req_count got=%0d exp=%0d", acc_addr.size(), DEPTH);
    end
    checks++;
    if (out_valid !== 1'b1 || imem_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_full got=%b/%b exp=1/0", out_valid, imem_req_valid);
    end
    out_ready = 1'b1; clear_records();
    repeat (6) step();
    checks++;
    if (acc_addr.size() == 0 || acc_addr[0] !== 32'h10) begin
      failures++;
      $display("FAIL stall_resume got=%h exp=%h",
               (acc_addr.size() > 0) ? acc_addr[0] : 32'hDEAD_BEEF, 32'h10);
    end
  endtask

  task automatic test_redirect();
    do_reset(); clear_records();
    hold_resp = 1; lat_min = 1; lat_max = 1;
    imem_req_ready = 1'b1; out_ready = 1'b1;
    repeat (2) step();
    imem_req_ready = 1'b0;
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    step();
    redirect_valid = 1'b0;
    clear_records();
    hold_resp = 0; imem_req_ready = 1'b1;
    repeat (12) step();
    checks++;
    if (acc_addr.size() == 0 || acc_addr[0] !== 32'h100) begin
      failures++;
      $display("FAIL redirect_req got=%h exp=%h",
               (acc_addr.size() > 0) ? acc_addr[0] : 32'hDEAD_BEEF, 32'h100);
    end
    checks++;
    if (pop_pc.size() < 2 || pop_pc[0] !== 32'h100 || pop_pc[1] !== 32'h104) begin
      failures++;
      $display("FAIL redirect_out_pc got=%h exp=%h",
               (pop_pc.size() > 0) ? pop_pc[0] : 32'hDEAD_BEEF, 32'h100);
    end
  endtask

  task automatic test_fault();
    int idx;
    do_reset(); clear_records();
    hold_resp = 0; lat_min = 1; lat_max = 1; fault_addr = 32'h8;
    imem_req_ready = 1'b1; out_ready = 1'b1;
    repeat (10) step();
    idx = -1;
    for (int i = 0; i < pop_pc.size(); i++) if (idx < 0 && pop_pc[i] == 32'h8) idx = i;
    checks++;
    if (idx < 0 || pop_fault[idx] !== 1'b1) begin
      failures++;
      $display("FAIL fault_entry got=%b exp=1", (idx < 0) ? 1'bx : pop_fault[idx]);
    end
    checks++;
    if (idx < 0 || idx + 1 >= pop_pc.size() || pop_pc[idx+1] !== 32'hC || pop_fault[idx+1] !== 1'b0) begin
      failures++;
      $display("FAIL after_fault got_idx=%0d exp_pc=%h exp_fault=0", idx, 32'hC);
    end
    fault_addr = 32'hFFFF_FFFF;
  endtask

  task automatic test_latency();
    bit exp_m, exp_m1;
    do_reset();
    hold_resp = 1; lat_min = 1; lat_max = 1;
    imem_req_ready = 1'b1; out_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    step();
    clear_records();
    hold_resp = 0;
    repeat (2) step();
`ifdef FETCH_BUFFER_BYPASS_EN
    exp_m = 1'b1; exp_m1 = 1'b0;
`else
    exp_m = 1'b0; exp_m1 = 1'b1;
`endif
    checks++;
    if (obs_ov.size() < 2 || obs_ov[0] !== exp_m || obs_ov[1] !== exp_m1) begin
      failures++;
      $display("FAIL resp_latency got=%b%b exp=%b%b", (obs_ov.size() > 0) ? obs_ov[0] : 1'b0,
               (obs_ov.size() > 1) ? obs_ov[1] : 1'b0, exp_m, exp_m1);
    end
    imem_req_ready = 1'b1;
  endtask

  task automatic test_reset_midflight();
    do_reset(); clear_records();
    hold_resp = 1; lat_min = 1; lat_max = 1;
    imem_req_ready = 1'b1; out_ready = 1'b0;
    repeat (4) step();
    hold_resp = 0;
    repeat (2) step();
    hold_resp = 1;
    step();
    checks++;
    if (out_valid !== 1'b1 || memq.size() != 2) begin
      failures++;
      $display("FAIL midflight_setup got=%b exp=1", out_valid);
    end
    reset = 1'b0; imem_resp_valid = 1'b0;
    #2;
    checks++;
    if (imem_req_valid !== 1'b0 || imem_req_addr !== START || out_valid !== 1'b0 ||
        out_pc !== 32'h0 || out_instr !== 32'h0 || out_fault !== 1'b0) begin
      failures++;
      $display("FAIL midflight_reset got=%b/%h/%b/%h/%h/%b", imem_req_valid, imem_req_addr,
               out_valid, out_pc, out_instr, out_fault);
    end
    do_reset(); clear_records();
    hold_resp = 0; out_ready = 1'b1;
    repeat (8) step();
    checks++;
    if (acc_addr.size() == 0 || acc_addr[0] !== START || pop_pc.size() < 3 || pop_pc[0] !== START) begin
      failures++;
      $display("FAIL midflight_restart got=%h exp=%h",
               (pop_pc.size() > 0) ? pop_pc[0] : 32'hDEAD_BEEF, START);
    end
  endtask

  task automatic test_random();
    do_reset(); clear_records();
    fault_rand = 1; lat_min = 1; lat_max = 4;
    for (int n = 0; n < 2000; n++) begin
      imem_req_ready = ($urandom_range(0, 9) < 7);
      out_ready      = ($urandom_range(0, 9) < 6);
      hold_resp      = ($urandom_range(0, 9) == 0);
      redirect_valid = ($urandom_range(0, 39) == 0);
      redirect_pc    = $urandom & 32'h0000_FFFF;
      step();
      redirect_valid = 1'b0;
    end
    fault_rand = 0;
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0; epoch = 0;
    hold_resp = 0; fault_rand = 0; fault_addr = 32'hFFFF_FFFF;
    lat_min = 1; lat_max = 1; exp_fetch_pc = START;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_fault();
    test_latency();
    test_reset_midflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
